// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry: scans a 4x4 hex keypad, debounces presses and assembles
// an operand pair (A then B) for the adder.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       synchronous reset, active low
//   i_row_n[3:0]  keypad rows, active low, asynchronous to i_clk
//   o_col_n[3:0]  keypad column drive, one-hot active low
//   o_key_valid   one-cycle pulse when a debounced key is accepted
//   o_key_code    code of the last accepted key (4*row + col)
//   o_op_a        operand A
//   o_op_b        operand B
//   o_ops_valid   one-cycle pulse when op_a/op_b form a complete pair
//   o_phase       entry state: 00 WAIT_A, 01 WAIT_B, 10 SHOW
module keypad_operand_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_row_n,
    output logic [3:0] o_col_n,
    output logic       o_key_valid,
    output logic [3:0] o_key_code,
    output logic [3:0] o_op_a,
    output logic [3:0] o_op_b,
    output logic       o_ops_valid,
    output logic [1:0] o_phase
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col;
    logic [3:0]    r_row_s1, r_row_s2;
    logic [15:0]   r_map;
    logic          r_cand_none;
    logic [3:0]    r_cand_code;
    logic [CW-1:0] r_cnt;
    logic          r_armed;
    logic          r_key_valid;
    logic [3:0]    r_key_code;
    state_t        r_state;
    logic [3:0]    r_op_a, r_op_b;
    logic          r_ops_valid;

    logic          w_tc, w_eval;
    logic [15:0]   w_frame;
    logic [4:0]    w_low_cnt;
    logic [3:0]    w_cand_code;
    logic          w_cand_none, w_same, w_hit, w_accept;
    logic [CW-1:0] w_cnt_next;
    state_t        w_state_next;
    logic [3:0]    w_op_a_next, w_op_b_next;
    logic          w_ops_valid_next;

    assign w_tc   = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_eval = w_tc && (r_col == 2'd3);

    // Scan timing: dwell counter and column index
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dwell <= '0;
            r_col   <= 2'd0;
        end else begin
            r_dwell <= w_tc ? '0 : r_dwell + DW'(1);
            r_col   <= w_tc ? r_col + 2'd1 : r_col;
        end
    end

    assign o_col_n = ~(4'b0001 << r_col);

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= i_row_n;
            r_row_s2 <= r_row_s1;
        end
    end

    // Frame map with the current column's rows overlaid, so the column-3
    // evaluation sees the complete frame in the same cycle it is sampled.
    always_comb begin
        w_frame = r_map;
        for (int r = 0; r < 4; r++)
            w_frame[4*r + int'(r_col)] = r_row_s2[r];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_map <= 16'hFFFF;
        else if (w_tc)
            r_map <= w_frame;
    end

    // A candidate exists only when exactly one key position reads low
    always_comb begin
        w_low_cnt   = 5'd0;
        w_cand_code = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (!w_frame[k]) begin
                w_low_cnt   = w_low_cnt + 5'd1;
                w_cand_code = 4'(k);
            end
        end
        w_cand_none = (w_low_cnt != 5'd1);
    end

    // NONE counts as a candidate value of its own for stability tracking
    assign w_same     = (w_cand_none && r_cand_none) ||
                        (!w_cand_none && !r_cand_none && (w_cand_code == r_cand_code));
    assign w_cnt_next = !w_same ? CW'(1) :
                        (r_cnt == CW'(DEBOUNCE)) ? r_cnt : r_cnt + CW'(1);
    assign w_hit      = (w_cnt_next == CW'(DEBOUNCE));
    assign w_accept   = w_eval && !w_cand_none && w_hit && r_armed;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cand_none <= 1'b1;
            r_cand_code <= 4'd0;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
        end else begin
            r_key_valid <= w_accept;
            if (w_eval) begin
                r_cand_none <= w_cand_none;
                r_cand_code <= w_cand_code;
                r_cnt       <= w_cnt_next;
                if (w_accept) begin
                    r_armed    <= 1'b0;
                    r_key_code <= w_cand_code;
                end else if (w_cand_none && w_hit) begin
                    r_armed <= 1'b1;
                end
            end
        end
    end

    // Entry FSM: state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= WAIT_A;
            r_op_a      <= 4'd0;
            r_op_b      <= 4'd0;
            r_ops_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_op_a      <= w_op_a_next;
            r_op_b      <= w_op_b_next;
            r_ops_valid <= w_ops_valid_next;
        end
    end

    // Entry FSM: next state and operand updates
    always_comb begin
        w_state_next     = r_state;
        w_op_a_next      = r_op_a;
        w_op_b_next      = r_op_b;
        w_ops_valid_next = 1'b0;
        if (r_key_valid) begin
            case (r_state)
                WAIT_A, SHOW: begin
                    w_op_a_next  = r_key_code;
                    w_op_b_next  = 4'd0;
                    w_state_next = WAIT_B;
                end
                WAIT_B: begin
                    w_op_b_next      = r_key_code;
                    w_ops_valid_next = 1'b1;
                    w_state_next     = SHOW;
                end
                default: w_state_next = WAIT_A;
            endcase
        end
    end

    assign o_key_valid = r_key_valid;
    assign o_key_code  = r_key_code;
    assign o_op_a      = r_op_a;
    assign o_op_b      = r_op_b;
    assign o_ops_valid = r_ops_valid;
    assign o_phase     = r_state;
endmodule

// File: tb/tb_keypad_operand_entry.sv
// tb_keypad_operand_entry: directed bench for the keypad operand entry block.
module tb_keypad_operand_entry;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid, ops_valid;
    logic [3:0]  key_code, op_a, op_b;
    logic [1:0]  phase;
    logic [15:0] keys = 16'h0000;

    int errors = 0;
    int checks = 0;
    int kv_tot = 0, ops_tot = 0, long_tot = 0;
    logic [3:0] last_code = 4'd0;
    logic prev_kv = 1'b0, prev_ops = 1'b0;
    int kv0, ops0;

    keypad_operand_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_row_n(row_n),
        .o_col_n(col_n),
        .o_key_valid(key_valid),
        .o_key_code(key_code),
        .o_op_a(op_a),
        .o_op_b(op_b),
        .o_ops_valid(ops_valid),
        .o_phase(phase)
    );

    always #5 clk = ~clk;

    // Keypad matrix model: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r + c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            kv_tot = kv_tot + 1;
            last_code = key_code;
        end
        if ((key_valid && prev_kv) || (ops_valid && prev_ops)) long_tot = long_tot + 1;
        if (ops_valid) ops_tot = ops_tot + 1;
        prev_kv = key_valid;
        prev_ops = ops_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        kv0 = kv_tot;
        ops0 = ops_tot;
    endtask

    initial begin
        // 1: reset state and scan sequence
        cyc(3);
        chk("rst_col_n", 32'(col_n), 32'(4'b1110));
        chk("rst_op_a", 32'(op_a), 0);
        chk("rst_op_b", 32'(op_b), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_ops_valid", 32'(ops_valid), 0);
        chk("rst_key_code", 32'(key_code), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("scan_col_n", 32'(col_n), 32'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
            cyc(1);
        end
        // 2: arm, then key 6 (row1/col2)
        mark();
        cyc(48);
        keys = 16'h0040;
        cyc(80);
        chk("k6_pulses", kv_tot - kv0, 1);
        chk("k6_code", 32'(last_code), 6);
        chk("k6_op_a", 32'(op_a), 6);
        chk("k6_op_b", 32'(op_b), 0);
        chk("k6_phase", 32'(phase), 1);
        chk("k6_ops", ops_tot - ops0, 0);
        // 3: release, then key 9 (row2/col1), held long
        keys = 16'h0000;
        cyc(48);
        mark();
        keys = 16'h0200;
        cyc(80);
        chk("k9_pulses", kv_tot - kv0, 1);
        chk("k9_code", 32'(last_code), 9);
        chk("k9_op_a", 32'(op_a), 6);
        chk("k9_op_b", 32'(op_b), 9);
        chk("k9_ops", ops_tot - ops0, 1);
        chk("k9_phase", 32'(phase), 2);
        cyc(160);
        chk("k9_held_pulses", kv_tot - kv0, 1);
        chk("k9_held_ops", ops_tot - ops0, 1);
        // 4: from SHOW, key 15 starts a new pair
        keys = 16'h0000;
        cyc(48);
        mark();
        keys = 16'h8000;
        cyc(80);
        chk("k15_pulses", kv_tot - kv0, 1);
        chk("k15_code", 32'(last_code), 15);
        chk("k15_op_a", 32'(op_a), 15);
        chk("k15_op_b", 32'(op_b), 0);
        chk("k15_phase", 32'(phase), 1);
        chk("k15_ops", ops_tot - ops0, 0);
        // 5: bouncing key 0, then two keys together
        keys = 16'h0000;
        cyc(48);
        mark();
        for (int i = 0; i < 11; i++) begin
            keys = keys ^ 16'h0001;
            cyc(3);
        end
        keys = 16'h0001;
        cyc(80);
        chk("bounce_pulses", kv_tot - kv0, 1);
        chk("bounce_code", 32'(last_code), 0);
        chk("bounce_op_b", 32'(op_b), 0);
        chk("bounce_phase", 32'(phase), 2);
        keys = 16'h0000;
        cyc(48);
        mark();
        keys = 16'h0021;
        cyc(80);
        chk("dual_pulses", kv_tot - kv0, 0);
        keys = 16'h0000;
        cyc(48);
        // 6: key 5 held through a mid-frame reset
        mark();
        keys = 16'h0020;
        cyc(6);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        chk("rst6_phase", 32'(phase), 0);
        chk("rst6_op_a", 32'(op_a), 0);
        cyc(96);
        chk("held_rst_pulses", kv_tot - kv0, 0);
        keys = 16'h0000;
        cyc(48);
        mark();
        keys = 16'h0020;
        cyc(80);
        chk("k5_pulses", kv_tot - kv0, 1);
        chk("k5_code", 32'(last_code), 5);
        chk("k5_op_a", 32'(op_a), 5);
        chk("k5_phase", 32'(phase), 1);
        chk("pulse_width", long_tot, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
